mem_stage_pl: RTL and testbench
===============================

MEM_STAGE_PL -- requirements
Module: mem_stage_pl

Interface
REQ-001 Parameters SHALL be: DW, default 16, data width; AW, default 16, address/PC width; TMO, default 15, max memory wait cycles before error.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; the ports SHALL be exactly:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  upstream (EX/MEM) entry valid.
in_ready  out  1  block accepts entry this cycle.
in_pc  in  AW  PC+2 of instruction.
in_addr  in  AW  ALU result / memory address.
in_wdata  in  DW  store data.
in_rd, in_wr  in  1 each  load / store request.
in_brtaken  in  1  branch condition true.
in_alujmp  in  1  register-indirect jump.
in_off  in  AW  sign-extended branch offset.
in_regsrc  in  1  writeback source (1=memory, 0=ALU).
in_setrd, in_wb  in  1 each  sideband flags, passed through.
mem_req, mem_wr  out  1 each  memory request / write.
mem_addr  out  AW  memory address.
mem_wdata  out  DW  memory write data.
mem_rdata  in  DW  memory read data.
mem_done  in  1  memory completes request this cycle.
out_valid  out  1  MEM/WB entry valid.
out_ready  in  1  WB consumes entry.
out_data  out  DW  writeback value.
out_setrd, out_wb  out  1 each  registered sideband.
out_err  out  1  entry faulted (misaligned or timeout).
redir_valid  out  1  one-cycle PC redirect pulse.
redir_pc  out  AW  redirect target.

Function
REQ-003 in_ready SHALL equal (state==IDLE) and (!out_valid or out_ready); accept = in_valid and in_ready.
REQ-004 FSM states SHALL be IDLE and BUSY; IDLE->BUSY on accept with (in_rd or in_wr) and in_addr[0]==0; BUSY->IDLE on mem_done or timeout; all else stays.
REQ-005 An accepted entry with no memory op SHALL present out_valid=1 on the next cycle (latency 1), out_data=in_addr (zero-extended/truncated to DW).
REQ-006 An accepted memory op with in_addr[0]==1 SHALL issue no request and present out_valid=1, out_err=1, out_data=0 next cycle.
REQ-007 In BUSY, mem_req SHALL be 1 with mem_addr/mem_wdata/mem_wr held from the captured entry, and SHALL drop in the cycle after mem_done.
REQ-008 On mem_done in BUSY, out_valid SHALL rise next cycle with out_data=mem_rdata if captured regsrc=1, else captured address; out_err=0.
REQ-009 A wait counter SHALL count BUSY cycles; when it reaches TMO without mem_done, the block SHALL drop mem_req, return to IDLE and emit the entry with out_err=1, out_data=0.
REQ-010 out_valid and out_* SHALL hold stable until out_valid and out_ready; then clear unless a new entry loads in the same cycle.
REQ-011 On accept with in_alujmp or in_brtaken, redir_valid SHALL pulse for exactly one cycle next cycle, independent of memory wait; redir_pc = in_alujmp ? in_addr : in_pc+in_off (modulo 2^AW, in_alujmp priority).
REQ-012 mem_done in IDLE SHALL be ignored.
REQ-013 out_setrd/out_wb SHALL be the captured in_setrd/in_wb of the same entry.

Reset
REQ-014 rst SHALL dominate all events: next cycle state=IDLE, counter=0, mem_req=0, mem_wr=0, out_valid=0, out_err=0, redir_valid=0, out_data=0, redir_pc=0.
REQ-015 Reset in BUSY SHALL abandon the request; a mem_done after reset SHALL produce no output.

Structure
REQ-016 A shared package SHALL hold the FSM state encoding and default DW/AW/TMO constants.
REQ-017 Target computation SHALL use a sub-module branch_target (AW-bit adder plus select); FSM, counter and output register stay in mem_stage_pl.

Verification
REQ-018 ALU entry addr=0x1234, no mem op, out_ready=1 -> out_valid next cycle, out_data=0x1234.
REQ-019 Load addr=0x0010, mem_done after 3 cycles, rdata=0xBEEF, regsrc=1 -> mem_req high 3 cycles, in_ready=0 during BUSY, out_data=0xBEEF.
REQ-020 Load addr=0x0011 -> mem_req never asserted, out_err=1 next cycle.
REQ-021 Store, mem_done never, TMO=15 -> mem_req dropped after 15 cycles, out_err=1.
REQ-022 Branch pc=0x0100, off=0xFFFC, brtaken=1 -> redir_valid one cycle, redir_pc=0x00FC; alujmp addr=0x4000 -> redir_pc=0x4000.
REQ-023 out_ready=0 with out_valid=1 -> in_ready=0, outputs stable; rst asserted in BUSY -> mem_req=0 next cycle, later mem_done yields no out_valid.

Source files
------------

// File: rtl/mem_stage_pl_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding and default sizing.
package mem_stage_pl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEFAULT_DW  = 16;
  localparam int DEFAULT_AW  = 16;
  localparam int DEFAULT_TMO = 15;

endpackage

// File: rtl/mem_stage_pl_branch_target.sv
// Redirect target: register-indirect jump address wins over PC-relative branch.
module branch_target #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] off,
  input  logic [AW-1:0] addr,
  input  logic          alujmp,
  output logic [AW-1:0] target
);

  logic [AW-1:0] rel_target;

  assign rel_target = pc + off;
  assign target     = alujmp ? addr : rel_target;

endmodule

// File: rtl/mem_stage_pl.sv
// MEM pipeline stage: issues one memory request per entry, bounds the wait,
// and forwards a registered MEM/WB entry plus a one-cycle PC redirect.
module mem_stage_pl
  import mem_stage_pl_pkg::*;
#(
  parameter int DW  = DEFAULT_DW,
  parameter int AW  = DEFAULT_AW,
  parameter int TMO = DEFAULT_TMO
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_pc,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic          in_rd,
  input  logic          in_wr,
  input  logic          in_brtaken,
  input  logic          in_alujmp,
  input  logic [AW-1:0] in_off,
  input  logic          in_regsrc,
  input  logic          in_setrd,
  input  logic          in_wb,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_setrd,
  output logic          out_wb,
  output logic          out_err,
  output logic          redir_valid,
  output logic [AW-1:0] redir_pc
);

  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          cap_regsrc;
  logic          cap_setrd;
  logic          cap_wb;

  logic          accept;
  logic          mem_op;
  logic          start_mem;
  logic          timeout;
  logic          finish;
  logic          redir_hit;
  logic [AW-1:0] target;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mem_op    = in_rd || in_wr;
  assign start_mem = accept && mem_op && !in_addr[0];
  assign timeout   = (state == BUSY) && !mem_done && (wait_cnt == CW'(TMO - 1));
  assign finish    = (state == BUSY) && (mem_done || timeout);
  assign redir_hit = accept && (in_alujmp || in_brtaken);

  branch_target #(.AW(AW)) u_target (
    .pc     (in_pc),
    .off    (in_off),
    .addr   (in_addr),
    .alujmp (in_alujmp),
    .target (target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cap_regsrc  <= 1'b0;
      cap_setrd   <= 1'b0;
      cap_wb      <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_setrd   <= 1'b0;
      out_wb      <= 1'b0;
      out_err     <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else begin
      redir_valid <= redir_hit;
      if (redir_hit) begin
        redir_pc <= target;
      end

      case (state)
        IDLE: begin
          if (start_mem) begin
            state      <= BUSY;
            wait_cnt   <= '0;
            mem_req    <= 1'b1;
            mem_wr     <= in_wr;
            mem_addr   <= in_addr;
            mem_wdata  <= in_wdata;
            cap_regsrc <= in_regsrc;
            cap_setrd  <= in_setrd;
            cap_wb     <= in_wb;
          end
        end
        BUSY: begin
          if (finish) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_req  <= 1'b0;
            mem_wr   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Entries without an issued request complete immediately; a misaligned access faults.
      if (accept && !start_mem) begin
        out_valid <= 1'b1;
        out_err   <= mem_op;
        out_data  <= mem_op ? '0 : DW'(in_addr);
        out_setrd <= in_setrd;
        out_wb    <= in_wb;
      end else if (finish) begin
        out_valid <= 1'b1;
        out_err   <= timeout;
        out_data  <= timeout ? '0 : (cap_regsrc ? mem_rdata : DW'(mem_addr));
        out_setrd <= cap_setrd;
        out_wb    <= cap_wb;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_err   <= 1'b0;
        out_data  <= '0;
        out_setrd <= 1'b0;
        out_wb    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_pl.sv
// Transaction-level bench for mem_stage_pl: directed scenarios plus random entries
// checked against an expected-result model and a simple memory responder.
module tb_mem_stage_pl;

  localparam int TMO = 15;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pc;
  logic [15:0] in_addr;
  logic [15:0] in_wdata;
  logic        in_rd;
  logic        in_wr;
  logic        in_brtaken;
  logic        in_alujmp;
  logic [15:0] in_off;
  logic        in_regsrc;
  logic        in_setrd;
  logic        in_wb;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_setrd;
  logic        out_wb;
  logic        out_err;
  logic        redir_valid;
  logic [15:0] redir_pc;

  int checks = 0;
  int errors = 0;

  mem_stage_pl #(.DW(16), .AW(16), .TMO(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_addr     (in_addr),
    .in_wdata    (in_wdata),
    .in_rd       (in_rd),
    .in_wr       (in_wr),
    .in_brtaken  (in_brtaken),
    .in_alujmp   (in_alujmp),
    .in_off      (in_off),
    .in_regsrc   (in_regsrc),
    .in_setrd    (in_setrd),
    .in_wb       (in_wb),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_setrd   (out_setrd),
    .out_wb      (out_wb),
    .out_err     (out_err),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // One entry end to end. delay = BUSY cycle on which memory answers (beyond TMO means never).
  task automatic applyStimulus(input logic [15:0] pc, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] off,
                               input logic rd, input logic wr, input logic brtaken,
                               input logic alujmp, input logic regsrc, input logic setrd,
                               input logic wb, input int delay, input logic [15:0] rdata,
                               input int hold);
    logic        is_mem, mis, busy, exp_err, exp_redir;
    logic [15:0] exp_data, exp_pc;
    int          exp_req, exp_lat, reqcnt, seen_at;

    is_mem    = rd || wr;
    mis       = is_mem && addr[0];
    busy      = is_mem && !addr[0];
    exp_req   = busy ? ((delay < TMO) ? delay : TMO) : 0;
    exp_lat   = 1 + exp_req;
    exp_err   = mis || (busy && delay > TMO);
    if (!is_mem)      exp_data = addr;
    else if (exp_err) exp_data = 16'h0000;
    else              exp_data = regsrc ? rdata : addr;
    exp_redir = alujmp || brtaken;
    exp_pc    = alujmp ? addr : 16'((32'(pc) + 32'(off)) % 32'h10000);

    @(negedge clk);
    checkOutput("in_ready_idle", in_ready, 1);
    in_pc = pc; in_addr = addr; in_wdata = wdata; in_off = off;
    in_rd = rd; in_wr = wr; in_brtaken = brtaken; in_alujmp = alujmp;
    in_regsrc = regsrc; in_setrd = setrd; in_wb = wb;
    in_valid = 1'b1;
    mem_done = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;

    reqcnt  = 0;
    seen_at = 0;
    for (int n = 1; n <= 40 && seen_at == 0; n++) begin
      if (n == 1) begin
        checkOutput("redir_valid", redir_valid, exp_redir);
        if (exp_redir) checkOutput("redir_pc", redir_pc, exp_pc);
      end
      if (n == 2) checkOutput("redir_pulse_end", redir_valid, 0);
      if (mem_req) begin
        reqcnt++;
        checkOutput("mem_addr", mem_addr, addr);
        checkOutput("mem_wr", mem_wr, wr);
        if (wr) checkOutput("mem_wdata", mem_wdata, wdata);
        checkOutput("in_ready_busy", in_ready, 0);
      end
      if (out_valid) begin
        seen_at = n;
      end else begin
        if (mem_req && reqcnt == delay) begin
          mem_done  = 1'b1;
          mem_rdata = rdata;
        end else begin
          mem_done  = mem_req ? 1'b0 : 1'($urandom_range(0, 1));
          mem_rdata = 16'($urandom);
        end
        @(negedge clk);
      end
    end
    mem_done = 1'b0;

    checkOutput("out_seen", 32'(seen_at != 0), 1);
    if (seen_at != 0) begin
      checkOutput("out_latency", seen_at, exp_lat);
      checkOutput("req_cycles", reqcnt, exp_req);
      checkOutput("out_data", out_data, exp_data);
      checkOutput("out_err", out_err, exp_err);
      checkOutput("out_setrd", out_setrd, setrd);
      checkOutput("out_wb", out_wb, wb);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, exp_data);
        checkOutput("hold_err", out_err, exp_err);
        checkOutput("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("out_cleared", out_valid, 0);
      checkOutput("redir_quiet", redir_valid, 0);
      checkOutput("req_quiet", mem_req, 0);
    end
  endtask

  // Abandon a request with reset; a late memory response must not produce an entry.
  task automatic resetInBusy();
    @(negedge clk);
    in_addr = 16'h0020; in_rd = 1'b1; in_wr = 1'b0; in_regsrc = 1'b1;
    in_brtaken = 1'b0; in_alujmp = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("rstbusy_req_before", mem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstbusy_req", mem_req, 0);
    checkOutput("rstbusy_valid", out_valid, 0);
    checkOutput("rstbusy_in_ready", in_ready, 1);
    mem_done  = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstbusy_no_out", out_valid, 0);
      checkOutput("rstbusy_no_req", mem_req, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_addr = '0; in_wdata = '0; in_off = '0;
    in_rd = 1'b0; in_wr = 1'b0; in_brtaken = 1'b0; in_alujmp = 1'b0;
    in_regsrc = 1'b0; in_setrd = 1'b0; in_wb = 1'b0;
    mem_rdata = '0; mem_done = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_wr", mem_wr, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_err", out_err, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_redir_valid", redir_valid, 0);
    checkOutput("rst_redir_pc", redir_pc, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // pc, addr, wdata, off, rd, wr, brtaken, alujmp, regsrc, setrd, wb, delay, rdata, hold
    applyStimulus(16'h0000, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 0);
    applyStimulus(16'h0000, 16'h0010, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 0, 1, 3, 16'hBEEF, 0);
    applyStimulus(16'h0000, 16'h0011, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 1, 0, 3, 16'h5555, 0);
    applyStimulus(16'h0000, 16'h0040, 16'hA5A5, 16'h0000, 0, 1, 0, 0, 0, 0, 1, 100, 16'h0000, 0);
    applyStimulus(16'h0100, 16'h2222, 16'h0000, 16'hFFFC, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
    applyStimulus(16'h0100, 16'h4000, 16'h0000, 16'h0008, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 0);
    applyStimulus(16'h0000, 16'h0ABC, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 3);
    applyStimulus(16'h0200, 16'h0030, 16'h0000, 16'h0010, 1, 0, 1, 0, 0, 1, 1, 5, 16'h7777, 2);
    applyStimulus(16'h0000, 16'h0050, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 0, 0, TMO, 16'h1357, 0);

    resetInBusy();

    for (int t = 0; t < 40; t++) begin
      int          op;
      logic [15:0] addr;
      op   = $urandom_range(0, 2);
      addr = 16'($urandom);
      if ($urandom_range(0, 3) != 0) addr[0] = 1'b0;
      applyStimulus(16'($urandom), addr, 16'($urandom), 16'($urandom),
                    op == 1, op == 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, TMO + 3), 16'($urandom), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
